iter_muldiv_unit: RTL and testbench
===================================

Name: iter_muldiv_unit

Overview:
- Multi-cycle RV32M/RV64M multiply/divide unit for the EX stage of the pipelined core.
- Generalises the single-cycle ALU path:
  - XLEN-parametrised.
  - Iterative shift-add multiply and restoring divide.
  - Explicit start/done handshake, plus a flush input for branch squash.
- The hazard logic holds ID/EX while busy is high; the result is written into EX/MEM on done.

Parameters:
XLEN, 32, operand/result width in bits (32 or 64)
CNT_W, $clog2(XLEN)+1, iteration counter width (derived, not overridden)

Ports:
clk  input  1  core clock, rising edge
rst  input  1  synchronous active-high reset
start  input  1  request; sampled only when busy==0
func3  input  3  M-extension funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
op_a  input  XLEN  rs1 operand (forwarded value)
op_b  input  XLEN  rs2 operand (forwarded value)
flush  input  1  abort the in-flight operation (branch/jump squash)
busy  output  1  high while an operation is in flight, including the done cycle
done  output  1  one-cycle pulse; result is valid
result  output  XLEN  selected result; held until the next accepted start

Behaviour:
- Reset (rst=1 at a rising edge):
  - State goes to IDLE; busy=0, done=0, result=0; all internal registers cleared.
  - Reset overrides start and flush in the same cycle.
- States:
  - IDLE: on start (busy==0), latch func3, magnitudes of op_a/op_b, and sign flags.
    - Fast case → FIN.
    - Otherwise → CALC with counter=XLEN.
  - CALC: one iteration per cycle. Counter decrements; at 1 → FIN.
  - FIN: done=1 and result driven for exactly one cycle; → IDLE.
- Latency, with start sampled in cycle k:
  - Normal ops: done in cycle k+XLEN+1; busy high cycles k+1..k+XLEN+1.
  - Fast case: done in cycle k+1; busy high in cycle k+1 only.
- Sign handling:
  - Signed operands are converted to magnitude at accept. Signedness:
    - MUL, MULH, DIV, REM: both operands signed.
    - MULHSU: op_a signed only.
    - MULHU, DIVU, REMU: unsigned.
  - MUL/MULH*: final 2*XLEN product negated when the operand signs differ.
  - DIV: quotient negated when the signs differ.
  - REM: remainder takes the sign of op_a.
- Multiply:
  - Product register is 2*XLEN bits.
  - Each iteration: if multiplier LSB=1, add the multiplicand to the upper half; then shift right by 1 including the carry.
  - MUL returns product[XLEN-1:0]; MULH* return product[2*XLEN-1:XLEN].
- Divide:
  - Restoring, one quotient bit per iteration, MSB first.
  - Remainder register is XLEN+1 bits to hold the borrow.
- Fast cases (no CALC state):
  - Divisor==0: DIV/DIVU → all ones; REM/REMU → op_a.
  - Signed overflow (op_a = 1<<(XLEN-1), op_b = all ones) for DIV/REM: DIV → op_a; REM → 0.
- flush:
  - Asserted in any cycle with busy=1 → IDLE next cycle.
  - No done pulse; result keeps its previous value.
  - flush in the FIN cycle: done still fires in that cycle (already committed).
  - flush with busy=0 is ignored.
  - flush and start in the same cycle while idle: start wins.
- start while busy=1 is ignored; no queueing. The caller must hold its request until busy falls.
- Operand inputs are don't-care after the accept cycle; they are fully latched internally.
- done and busy are registered outputs; result is registered.

Test Plan:
- MUL 7 × 0xFFFFFFFD (−3), XLEN=32, start in cycle 0:
  - done in cycle 33 only, with result=0xFFFFFFEB.
  - busy=1 in cycles 1..33, 0 in cycle 34.
- High-half multiplies:
  - MULH 0x80000000×0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- Divides, each with done at start+33:
  - DIV 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFD.
  - REM −7 / 2 → 0xFFFFFFFF.
  - DIVU 0xFFFFFFF9 / 2 → 0x7FFFFFFC.
  - REMU 100 / 7 → 2.
- Fast cases:
  - DIV 5/0 → 0xFFFFFFFF; REMU 5/0 → 5.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM of the same → 0.
  - Each gives done in cycle start+1, with busy high for that single cycle.
- Flush and reset mid-operation:
  - flush at start+10 → busy=0 at start+11, no done, result unchanged.
  - A new MUL 3×4 started at start+11 → 12 at +33 from the new start.
  - rst mid-CALC → busy=0, done=0, result=0 next cycle.
- Start while busy:
  - A second start with different operands during CALC is ignored; only the first result appears.
- XLEN=64 smoke test: MULHU 0xFFFF…F × 2 → 1; done at start+65.

Source files
------------

// File: rtl/iter_muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit for the EX stage.
// Shift-add multiply and restoring divide, one bit per cycle, with a
// start/busy/done handshake and a flush input for branch squash.
// Division by zero and signed overflow finish without iterating.
module iter_muldiv_unit #(
  parameter  int XLEN  = 32,
  localparam int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam logic [2:0] F_MUL    = 3'b000;
  localparam logic [2:0] F_MULH   = 3'b001;
  localparam logic [2:0] F_MULHSU = 3'b010;
  localparam logic [2:0] F_MULHU  = 3'b011;
  localparam logic [2:0] F_DIV    = 3'b100;
  localparam logic [2:0] F_DIVU   = 3'b101;
  localparam logic [2:0] F_REM    = 3'b110;
  localparam logic [2:0] F_REMU   = 3'b111;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t state_q, state_nxt;

  // Latched operation context.
  logic [2:0]        f3_q;
  logic              neg_q;     // negate final product/quotient/remainder
  logic [CNT_W-1:0]  cnt_q;
  logic [XLEN-1:0]   mcand_q;   // multiplicand (mul) or divisor (div)
  logic [2*XLEN-1:0] prod_q;    // product (mul); low half is quotient (div)
  logic [XLEN:0]     rem_q;     // partial remainder, extra bit holds borrow
  logic              busy_q;
  logic              done_q;
  logic [XLEN-1:0]   result_q;

  // Accept-time operand decode, evaluated on the raw inputs.
  logic            a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div_zero, div_ovf, fast;
  logic [XLEN-1:0] fast_val;

  assign a_signed = (func3 == F_MUL) || (func3 == F_MULH) || (func3 == F_MULHSU) ||
                    (func3 == F_DIV) || (func3 == F_REM);
  assign b_signed = (func3 == F_MUL) || (func3 == F_MULH) ||
                    (func3 == F_DIV) || (func3 == F_REM);
  assign a_neg    = a_signed && op_a[XLEN-1];
  assign b_neg    = b_signed && op_b[XLEN-1];
  assign a_mag    = a_neg ? -op_a : op_a;
  assign b_mag    = b_neg ? -op_b : op_b;

  assign div_zero = func3[2] && (op_b == '0);
  assign div_ovf  = ((func3 == F_DIV) || (func3 == F_REM)) &&
                    (op_a == MIN_NEG) && (op_b == '1);
  assign fast     = div_zero || div_ovf;
  // REM/REMU have func3[1] set; DIV/DIVU do not.
  assign fast_val = div_zero ? (func3[1] ? op_a : '1)
                             : (func3[1] ? '0   : op_a);

  // One multiply step: conditional add into the upper half, then shift
  // right together with the carry out of that add.
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_nxt;

  assign mul_sum = prod_q[0] ? ({1'b0, prod_q[2*XLEN-1:XLEN]} + {1'b0, mcand_q})
                             :  {1'b0, prod_q[2*XLEN-1:XLEN]};
  assign mul_nxt = {mul_sum, prod_q[XLEN-1:1]};

  // One restoring divide step: bring in the next dividend bit, trial
  // subtract, keep the difference only when it did not borrow.
  logic [XLEN:0]   div_shift;
  logic [XLEN+1:0] div_diff;
  logic            div_borrow;
  logic [XLEN:0]   rem_nxt;
  logic [XLEN-1:0] quo_nxt;

  assign div_shift  = {rem_q[XLEN-1:0], prod_q[XLEN-1]};
  assign div_diff   = {1'b0, div_shift} - {2'b00, mcand_q};
  assign div_borrow = div_diff[XLEN+1];
  assign rem_nxt    = div_borrow ? div_shift : div_diff[XLEN:0];
  assign quo_nxt    = {prod_q[XLEN-2:0], ~div_borrow};

  // Sign fix-up and result selection from the values the last step produces.
  logic [2*XLEN-1:0] prod_fin;
  logic [XLEN-1:0]   quo_fin, rem_fin, calc_res;

  assign prod_fin = neg_q ? -mul_nxt : mul_nxt;
  assign quo_fin  = neg_q ? -quo_nxt : quo_nxt;
  assign rem_fin  = neg_q ? -rem_nxt[XLEN-1:0] : rem_nxt[XLEN-1:0];

  always_comb begin
    // NOTE: every signal written in always_comb gets a default first so no path leaves it unassigned (which would infer a latch).
    calc_res = prod_fin[2*XLEN-1:XLEN];
    case (f3_q)
      F_MUL:          calc_res = prod_fin[XLEN-1:0];
      F_DIV, F_DIVU:  calc_res = quo_fin;
      F_REM, F_REMU:  calc_res = rem_fin;
      default:        calc_res = prod_fin[2*XLEN-1:XLEN];
    endcase
  end

  logic accept, step, last_step;

  assign accept    = (state_q == S_IDLE) && start;
  assign step      = (state_q == S_CALC) && !flush;
  assign last_step = step && (cnt_q == CNT_W'(1));

  // Next-state logic: accept, iterate, finish, or abandon on flush.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      S_IDLE: if (start) state_nxt = fast ? S_FIN : S_CALC;
      S_CALC: begin
        if (flush)                      state_nxt = S_IDLE;
        else if (cnt_q == CNT_W'(1))    state_nxt = S_FIN;
      end
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register plus registered busy/done decoded from the next state.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_nxt;
      busy_q  <= (state_nxt != S_IDLE);
      done_q  <= (state_nxt == S_FIN);
    end
  end

  // Datapath: latch operands at accept, step once per CALC cycle, capture result.
  always_ff @(posedge clk) begin
    if (rst) begin
      f3_q     <= '0;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      prod_q   <= '0;
      rem_q    <= '0;
      result_q <= '0;
    end else if (accept) begin
      f3_q    <= func3;
      neg_q   <= (func3 == F_REM) ? a_neg : (a_neg ^ b_neg);
      cnt_q   <= CNT_W'(XLEN);
      mcand_q <= func3[2] ? b_mag : a_mag;
      prod_q  <= {{XLEN{1'b0}}, (func3[2] ? a_mag : b_mag)};
      rem_q   <= '0;
      if (fast) result_q <= fast_val;
    end else if (step) begin
      cnt_q <= cnt_q - CNT_W'(1);
      if (f3_q[2]) begin
        prod_q <= {{XLEN{1'b0}}, quo_nxt};
        rem_q  <= rem_nxt;
      end else begin
        prod_q <= mul_nxt;
      end
      if (last_step) result_q <= calc_res;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_iter_muldiv_unit.sv
// Self-checking bench for iter_muldiv_unit: a directed vector table at
// XLEN=32 plus hand-written flush/reset/busy-start sequences and an
// XLEN=64 smoke test.
module tb_iter_muldiv_unit;

  localparam logic [2:0] F_MUL    = 3'b000;
  localparam logic [2:0] F_MULH   = 3'b001;
  localparam logic [2:0] F_MULHSU = 3'b010;
  localparam logic [2:0] F_MULHU  = 3'b011;
  localparam logic [2:0] F_DIV    = 3'b100;
  localparam logic [2:0] F_DIVU   = 3'b101;
  localparam logic [2:0] F_REM    = 3'b110;
  localparam logic [2:0] F_REMU   = 3'b111;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, flush;
  logic [2:0]  func3;
  logic [31:0] op_a, op_b;
  logic        busy, done;
  logic [31:0] result;

  logic        start64, flush64;
  logic [2:0]  func3_64;
  logic [63:0] op_a64, op_b64;
  logic        busy64, done64;
  logic [63:0] result64;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  iter_muldiv_unit #(.XLEN(32)) u_dut (
    .clk(clk), .rst(rst), .start(start), .func3(func3),
    .op_a(op_a), .op_b(op_b), .flush(flush),
    .busy(busy), .done(done), .result(result)
  );

  iter_muldiv_unit #(.XLEN(64)) u_dut64 (
    .clk(clk), .rst(rst), .start(start64), .func3(func3_64),
    .op_a(op_a64), .op_b(op_b64), .flush(flush64),
    .busy(busy64), .done(done64), .result(result64)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at a negedge; accepts at the next posedge (cycle k) and returns
  // at the negedge of the done cycle. lat is cycles after k, -1 on timeout.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic fl, output logic [31:0] res, output int lat,
                        output int busy_cnt);
    start = 1'b1; func3 = f; op_a = a; op_b = b; flush = fl;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    op_a = $urandom; op_b = $urandom; func3 = 3'($urandom);
    lat = -1; busy_cnt = 0; res = '0;
    for (int n = 1; n <= 100; n++) begin
      if (busy) busy_cnt++;
      if (done) begin
        lat = n; res = result;
        break;
      end
      @(negedge clk);
    end
  endtask

  typedef struct {
    string       name;
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[18];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] res, last_exp;
    int lat, bcnt, dcnt;

    vecs[0]  = '{"mul_7_m3",      F_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33};
    vecs[1]  = '{"mulh_min_min",  F_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 33};
    vecs[2]  = '{"mulhu_max_max", F_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33};
    vecs[3]  = '{"mulhsu_m1_max", F_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33};
    vecs[4]  = '{"mulh_m1_m1",    F_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33};
    vecs[5]  = '{"mul_3_4",       F_MUL,    32'd3,        32'd4,        32'd12,       33};
    vecs[6]  = '{"div_m7_2",      F_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33};
    vecs[7]  = '{"rem_m7_2",      F_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33};
    vecs[8]  = '{"divu_big_2",    F_DIVU,   32'hFFFFFFF9, 32'd2,        32'h7FFFFFFC, 33};
    vecs[9]  = '{"remu_100_7",    F_REMU,   32'd100,      32'd7,        32'd2,        33};
    vecs[10] = '{"div_7_m2",      F_DIV,    32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 33};
    vecs[11] = '{"rem_7_m2",      F_REM,    32'd7,        32'hFFFFFFFE, 32'd1,        33};
    vecs[12] = '{"divu_min_max",  F_DIVU,   32'h80000000, 32'hFFFFFFFF, 32'd0,        33};
    vecs[13] = '{"div_5_0",       F_DIV,    32'd5,        32'd0,        32'hFFFFFFFF, 1};
    vecs[14] = '{"remu_5_0",      F_REMU,   32'd5,        32'd0,        32'd5,        1};
    vecs[15] = '{"div_ovf",       F_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
    vecs[16] = '{"rem_ovf",       F_REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        1};
    vecs[17] = '{"remu_min_max",  F_REMU,   32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33};

    // Reset, with start/flush asserted to show reset dominates.
    rst = 1'b1; start = 1'b1; flush = 1'b1; func3 = F_MUL; op_a = 32'd9; op_b = 32'd9;
    start64 = 1'b0; flush64 = 1'b0; func3_64 = '0; op_a64 = '0; op_b64 = '0;
    repeat (3) @(negedge clk);
    check("reset_busy",   64'(busy),   64'd0);
    check("reset_done",   64'(done),   64'd0);
    check("reset_result", 64'(result), 64'd0);
    rst = 1'b0; start = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("idle_busy", 64'(busy), 64'd0);

    // Directed vector table.
    last_exp = '0;
    foreach (vecs[i]) begin
      run_op(vecs[i].f, vecs[i].a, vecs[i].b, 1'b0, res, lat, bcnt);
      check({vecs[i].name, "_result"},   64'(res),  64'(vecs[i].exp));
      check({vecs[i].name, "_latency"},  64'(lat),  64'(vecs[i].lat));
      check({vecs[i].name, "_busy_cyc"}, 64'(bcnt), 64'(vecs[i].lat));
      @(negedge clk);
      check({vecs[i].name, "_busy_after"}, 64'(busy),   64'd0);
      check({vecs[i].name, "_done_after"}, 64'(done),   64'd0);
      check({vecs[i].name, "_held"},       64'(result), 64'(vecs[i].exp));
      last_exp = vecs[i].exp;
    end

    // Flush while idle is ignored.
    flush = 1'b1;
    repeat (3) @(negedge clk);
    flush = 1'b0;
    check("idle_flush_busy",   64'(busy),   64'd0);
    check("idle_flush_result", 64'(result), 64'(last_exp));

    // Flush at start+10: no done, result unchanged, busy low at start+11.
    start = 1'b1; func3 = F_DIV; op_a = 32'd100; op_b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    dcnt = 0;
    repeat (9) begin
      if (done) dcnt++;
      @(negedge clk);
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_no_done_before", 64'(dcnt),   64'd0);
    check("flush_busy",           64'(busy),   64'd0);
    check("flush_done",           64'(done),   64'd0);
    check("flush_result_held",    64'(result), 64'(last_exp));

    // New MUL accepted right after the flush.
    run_op(F_MUL, 32'd3, 32'd4, 1'b0, res, lat, bcnt);
    check("post_flush_mul_result",  64'(res), 64'd12);
    check("post_flush_mul_latency", 64'(lat), 64'd33);
    @(negedge clk);

    // flush together with start while idle: start wins.
    run_op(F_REMU, 32'd100, 32'd7, 1'b1, res, lat, bcnt);
    check("start_flush_idle_result",  64'(res), 64'd2);
    check("start_flush_idle_latency", 64'(lat), 64'd33);
    @(negedge clk);

    // flush in the FIN cycle of a fast op: done still fires.
    start = 1'b1; func3 = F_DIV; op_a = 32'd5; op_b = 32'd0;
    @(negedge clk);
    start = 1'b0; flush = 1'b1;
    check("fin_flush_done",   64'(done),   64'd1);
    check("fin_flush_result", 64'(result), 64'hFFFFFFFF);
    @(negedge clk);
    flush = 1'b0;
    check("fin_flush_busy_after", 64'(busy),   64'd0);
    check("fin_flush_held",       64'(result), 64'hFFFFFFFF);

    // A second start during CALC is ignored and not queued.
    start = 1'b1; func3 = F_MUL; op_a = 32'd5; op_b = 32'd6;
    @(negedge clk);
    start = 1'b0;
    lat = -1; res = '0;
    for (int n = 1; n <= 100; n++) begin
      if (n == 5 || n == 6) begin
        start = 1'b1; func3 = F_DIVU; op_a = 32'd1000; op_b = 32'd3;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        lat = n; res = result;
        break;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check("busy_start_result",  64'(res), 64'd30);
    check("busy_start_latency", 64'(lat), 64'd33);
    @(negedge clk);
    check("busy_start_not_queued", 64'(busy), 64'd0);
    @(negedge clk);
    check("busy_start_still_idle", 64'(busy), 64'd0);

    // Reset mid-CALC, with start and flush also high.
    start = 1'b1; func3 = F_MUL; op_a = 32'd7; op_b = 32'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    rst = 1'b1; start = 1'b1; flush = 1'b1;
    @(negedge clk);
    check("midcalc_rst_busy",   64'(busy),   64'd0);
    check("midcalc_rst_done",   64'(done),   64'd0);
    check("midcalc_rst_result", 64'(result), 64'd0);
    rst = 1'b0; start = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("post_rst_idle", 64'(busy), 64'd0);

    run_op(F_MULHU, 32'h12345678, 32'h10, 1'b0, res, lat, bcnt);
    check("post_rst_mulhu_result",  64'(res), 64'd1);
    check("post_rst_mulhu_latency", 64'(lat), 64'd33);
    @(negedge clk);

    // XLEN=64: MULHU all-ones x 2 -> 1, done at start+65.
    start64 = 1'b1; func3_64 = F_MULHU; op_a64 = '1; op_b64 = 64'd2;
    @(negedge clk);
    start64 = 1'b0; op_a64 = '0; op_b64 = '0;
    lat = -1; bcnt = 0;
    for (int n = 1; n <= 200; n++) begin
      if (busy64) bcnt++;
      if (done64) begin
        lat = n;
        break;
      end
      @(negedge clk);
    end
    check("x64_mulhu_result",   result64,  64'd1);
    check("x64_mulhu_latency",  64'(lat),  64'd65);
    check("x64_mulhu_busy_cyc", 64'(bcnt), 64'd65);
    @(negedge clk);
    check("x64_busy_after", 64'(busy64), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
